// File: rtl/comparator_tree_pipe.sv
// Two-stage pipelined magnitude comparator built from a tree of 2-bit (lt, gt) cells.
// Define CMP_MINMAX_EN to add the min_out/max_out operand outputs.
module comparator_tree_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned GROUP = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             lt,
    output logic             gt
`ifdef CMP_MINMAX_EN
    ,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out
`endif
);

    localparam int unsigned NG = WIDTH / GROUP;
    localparam int unsigned LW = $clog2(WIDTH);

    // Pairwise (lt, gt) reduction of the lowest n entries; higher index is more significant.
    function automatic logic [1:0] tree_reduce(
        input logic [WIDTH-1:0] lt_in,
        input logic [WIDTH-1:0] gt_in,
        input int unsigned      n
    );
        logic [WIDTH-1:0] l;
        logic [WIDTH-1:0] g;
        int unsigned      s;
        int unsigned      lo;
        int unsigned      hi;
        logic             nl;
        logic             ng;
        l = lt_in;
        g = gt_in;
        for (int unsigned lv = 0; lv < LW; lv++) begin
            s = 32'd1 << lv;
            for (int unsigned j = 0; j < WIDTH / 2; j++) begin
                lo = j << (lv + 1);
                hi = lo + s;
                if (hi < n) begin
                    nl = l[LW'(hi)] | (~g[LW'(hi)] & l[LW'(lo)]);
                    ng = g[LW'(hi)] | (~l[LW'(hi)] & g[LW'(lo)]);
                    l[LW'(lo)] = nl;
                    g[LW'(lo)] = ng;
                end
            end
        end
        return {g[0], l[0]};
    endfunction

    logic [WIDTH-1:0] am;
    logic [WIDTH-1:0] bm;
    logic [WIDTH-1:0] bit_lt;
    logic [WIDTH-1:0] bit_gt;
    logic [NG-1:0]    grp_lt;
    logic [NG-1:0]    grp_gt;
    logic [1:0]       root;
    logic             run;
    logic             s1_valid;
    logic [NG-1:0]    s1_lt;
    logic [NG-1:0]    s1_gt;
    logic             adv1;
    logic             load1;
`ifdef CMP_MINMAX_EN
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
`endif

    // Signed mode flips both sign bits so the unsigned tree orders two's-complement values.
    always_comb begin
        am             = a;
        bm             = b;
        am[WIDTH-1]    = a[WIDTH-1] ^ sgn;
        bm[WIDTH-1]    = b[WIDTH-1] ^ sgn;
        bit_lt         = ~am & bm;
        bit_gt         = am & ~bm;
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        assign {grp_gt[gi], grp_lt[gi]} = tree_reduce(WIDTH'(bit_lt[gi*GROUP +: GROUP]),
                                                      WIDTH'(bit_gt[gi*GROUP +: GROUP]), GROUP);
    end

    assign root     = tree_reduce(WIDTH'(s1_lt), WIDTH'(s1_gt), NG);
    assign adv1     = ~out_valid | out_ready;
    assign in_ready = run & (~s1_valid | adv1);
    assign load1    = in_valid & in_ready;

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Stage 1: per-group (lt, gt) pairs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_lt    <= '0;
            s1_gt    <= '0;
`ifdef CMP_MINMAX_EN
            s1_a     <= '0;
            s1_b     <= '0;
`endif
        end else if (load1) begin
            s1_valid <= 1'b1;
            s1_lt    <= grp_lt;
            s1_gt    <= grp_gt;
`ifdef CMP_MINMAX_EN
            s1_a     <= a;
            s1_b     <= b;
`endif
        end else if (adv1) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: final flags; everything reads zero while no result is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
`ifdef CMP_MINMAX_EN
            min_out   <= '0;
            max_out   <= '0;
`endif
        end else if (adv1) begin
            out_valid <= s1_valid;
            eq        <= s1_valid & ~(root[0] | root[1]);
            lt        <= s1_valid & root[0];
            gt        <= s1_valid & root[1];
`ifdef CMP_MINMAX_EN
            min_out   <= s1_valid ? (root[1] ? s1_b : s1_a) : '0;
            max_out   <= s1_valid ? (root[0] ? s1_b : s1_a) : '0;
`endif
        end
    end

endmodule

// File: tb/tb_comparator_tree_pipe.sv
// Randomized bench for comparator_tree_pipe at 8/2, 64/16 and 256/32 against a queue-based model.
// Define CMP_MINMAX_EN to also check min_out/max_out.
module tb_comparator_tree_pipe;

    typedef struct {
        logic [1:0]  c [3];
        logic [63:0] mn;
        logic [63:0] mx;
        int          cy;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         iv;
    logic         ordy;
    logic         sg;
    logic [255:0] a_r;
    logic [255:0] b_r;
    logic ir0, ir1, ir2, ov0, ov1, ov2;
    logic eq0, eq1, eq2, lt0, lt1, lt2, gt0, gt1, gt2;
`ifdef CMP_MINMAX_EN
    logic [7:0]   mn0, mx0;
    logic [63:0]  mn1, mx1;
    logic [255:0] mn2, mx2;
`endif

    ent_t q[$];
    int   cyc, n_cmp, n_bad, n_acc, n_out;
    bit   live;

    comparator_tree_pipe #(.WIDTH(8), .GROUP(2)) u_d0 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv), .in_ready(ir0),
        .a(a_r[7:0]), .b(b_r[7:0]), .sgn(sg), .out_valid(ov0), .out_ready(ordy),
        .eq(eq0), .lt(lt0), .gt(gt0)
`ifdef CMP_MINMAX_EN
        , .min_out(mn0), .max_out(mx0)
`endif
    );

    comparator_tree_pipe #(.WIDTH(64), .GROUP(16)) u_d1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv), .in_ready(ir1),
        .a(a_r[63:0]), .b(b_r[63:0]), .sgn(sg), .out_valid(ov1), .out_ready(ordy),
        .eq(eq1), .lt(lt1), .gt(gt1)
`ifdef CMP_MINMAX_EN
        , .min_out(mn1), .max_out(mx1)
`endif
    );

    comparator_tree_pipe #(.WIDTH(256), .GROUP(32)) u_d2 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv), .in_ready(ir2),
        .a(a_r), .b(b_r), .sgn(sg), .out_valid(ov2), .out_ready(ordy),
        .eq(eq2), .lt(lt2), .gt(gt2)
`ifdef CMP_MINMAX_EN
        , .min_out(mn2), .max_out(mx2)
`endif
    );

    // Reference: 0 = equal, 1 = a<b, 2 = a>b, using plain (signed) arithmetic on w-bit values.
    function automatic logic [1:0] ref_cmp(input logic [255:0] x, input logic [255:0] y,
                                           input logic s, input int w);
        logic signed [256:0] xs;
        logic signed [256:0] ys;
        logic [256:0]        m;
        m  = (257'(1) << w) - 257'(1);
        xs = {1'b0, x} & m;
        ys = {1'b0, y} & m;
        if (s && x[w-1]) xs = xs | ~m;
        if (s && y[w-1]) ys = ys | ~m;
        if (xs == ys) return 2'd0;
        if (xs < ys) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [2:0] code3(input logic [1:0] c);
        case (c)
            2'd0:    return 3'b100;
            2'd1:    return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input int d, input logic [255:0] got,
                       input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, d, got, exp, cyc);
        end
    endtask

    task automatic rand_ops();
        int k;
        sg  = 1'($urandom_range(0, 1));
        a_r = rand256();
        case ($urandom_range(0, 3))
            0: b_r = rand256();
            1: b_r = a_r;
            2: begin
                k   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
                b_r = a_r ^ (256'(1) << k);
            end
            default: begin
                b_r        = a_r;
                b_r[7:5]   = 3'($urandom);
                b_r[63:60] = 4'($urandom);
                b_r[255]   = ~a_r[255];
            end
        endcase
    endtask

    // Checks every visible output against the model, then advances the model's queue.
    task automatic sample();
        logic [2:0] ir_v;
        logic [2:0] ov_v;
        logic [2:0] f [3];
        bit         eir;
        bit         eov;
        ent_t       e;
        ir_v = {ir2, ir1, ir0};
        ov_v = {ov2, ov1, ov0};
        f[0] = {eq0, lt0, gt0};
        f[1] = {eq1, lt1, gt1};
        f[2] = {eq2, lt2, gt2};
        eir  = live && (q.size() < 2 || ordy);
        eov  = (q.size() > 0) && (cyc >= q[0].cy + 2);
        for (int d = 0; d < 3; d++) begin
            chk("in_ready", d, 256'(ir_v[d]), 256'(eir));
            chk("out_valid", d, 256'(ov_v[d]), 256'(eov));
            if (eov) begin
                chk("result", d, 256'(f[d]), 256'(code3(q[0].c[d])));
                chk("onehot", d, 256'($onehot(f[d])), 256'(1));
            end else begin
                chk("idle_flags", d, 256'(f[d]), 256'(0));
            end
        end
`ifdef CMP_MINMAX_EN
        if (eov) begin
            chk("min_out", 1, 256'(mn1), 256'(q[0].mn));
            chk("max_out", 1, 256'(mx1), 256'(q[0].mx));
        end else begin
            chk("idle_minmax", 1, 256'({mn1, mx1}), 256'(0));
        end
`endif
        if (eov && ordy) begin
            void'(q.pop_front());
            n_out++;
        end
        if (iv && eir) begin
            e.c[0] = ref_cmp(a_r, b_r, sg, 8);
            e.c[1] = ref_cmp(a_r, b_r, sg, 64);
            e.c[2] = ref_cmp(a_r, b_r, sg, 256);
            e.mn   = (e.c[1] == 2'd2) ? b_r[63:0] : a_r[63:0];
            e.mx   = (e.c[1] == 2'd1) ? b_r[63:0] : a_r[63:0];
            e.cy   = cyc;
            q.push_back(e);
            n_acc++;
        end
    endtask

    task automatic tick();
        #2;
        sample();
        @(posedge clk);
        cyc++;
        if (reset_n) live = 1'b1;
        #1;
    endtask

    initial begin
        int base;
        int pops;
        reset_n = 1'b0; iv = 1'b0; ordy = 1'b1; sg = 1'b0; a_r = '0; b_r = '0;
        cyc = 0; n_cmp = 0; n_bad = 0; n_acc = 0; n_out = 0; live = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tick(); tick();
        chk("reset_in_ready", 1, 256'(ir1), 256'(0));
        chk("reset_out_valid", 1, 256'(ov1), 256'(0));
        reset_n = 1'b1;
        tick();
        chk("ready_after_reset", 1, 256'(ir1), 256'(1));

        // Unsigned boundary, latency 2
        a_r = '0; b_r = '1; sg = 1'b0; iv = 1'b1;
        tick();
        iv = 1'b0;
        chk("lat1_out_valid", 1, 256'(ov1), 256'(0));
        tick();
        chk("lat2_out_valid", 1, 256'(ov1), 256'(1));
        chk("unsigned_lt", 1, 256'({eq1, lt1, gt1}), 256'(3'b010));
        a_r = '1; b_r = '1; iv = 1'b1;
        tick();
        iv = 1'b0;
        tick();
        chk("all_ones_eq", 1, 256'({eq1, lt1, gt1}), 256'(3'b100));
        tick();

        // Signed vs unsigned boundary, back to back
        a_r = 256'h8000_0000_0000_0000; b_r = 256'h7FFF_FFFF_FFFF_FFFF; sg = 1'b1; iv = 1'b1;
        tick();
        sg = 1'b0;
        tick();
        iv = 1'b0;
        chk("signed_lt", 1, 256'({eq1, lt1, gt1}), 256'(3'b010));
        tick();
        chk("unsigned_gt", 1, 256'({eq1, lt1, gt1}), 256'(3'b001));
        tick(); tick();

        // Eight pairs with out_ready low on cycles 3-6
        base = n_acc;
        pops = n_out;
        for (int i = 0; i < 30; i++) begin
            iv   = (n_acc - base) < 8;
            ordy = !(i >= 3 && i <= 6);
            if (iv) rand_ops();
            #1;
            if (i == 4) chk("stall_in_ready", 1, 256'(ir1), 256'(0));
            tick();
        end
        chk("stall_results", 1, 256'(n_out - pops), 256'(8));
        ordy = 1'b1;

        // Reset with two transactions in flight
        iv = 1'b1;
        rand_ops(); tick();
        rand_ops(); tick();
        iv = 1'b0;
        chk("pre_reset_out_valid", 1, 256'(ov1), 256'(1));
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", 1, 256'(ov1), 256'(0));
        chk("async_flags", 1, 256'({eq1, lt1, gt1}), 256'(0));
        chk("async_in_ready", 1, 256'(ir1), 256'(0));
        q.delete();
        live = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        a_r = 256'd5; b_r = 256'd9; sg = 1'b0; iv = 1'b1;
        tick();
        iv = 1'b0;
        chk("post_reset_lat1", 1, 256'(ov1), 256'(0));
        tick();
        chk("post_reset_lat2", 1, 256'(ov1), 256'(1));
        chk("post_reset_lt", 1, 256'({eq1, lt1, gt1}), 256'(3'b010));
        tick();

`ifdef CMP_MINMAX_EN
        a_r = '1 - 256'd4; b_r = 256'd3; sg = 1'b1; iv = 1'b1;
        tick();
        iv = 1'b0;
        tick();
        chk("minmax_min", 1, 256'(mn1), 256'(64'hFFFF_FFFF_FFFF_FFFB));
        chk("minmax_max", 1, 256'(mx1), 256'(64'd3));
        chk("minmax_lt", 1, 256'(lt1), 256'(1));
        tick();
`endif

        // Random sweep with random valid and backpressure
        base = n_acc;
        for (int i = 0; i < 40000 && (n_acc - base) < 10000; i++) begin
            iv   = ($urandom_range(0, 9) < 8);
            ordy = ($urandom_range(0, 3) != 0);
            rand_ops();
            tick();
        end
        chk("sweep_count", 1, 256'((n_acc - base) >= 10000), 256'(1));

        iv = 1'b0; ordy = 1'b1;
        repeat (4) tick();
        chk("drain_empty", 1, 256'(q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
